// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit CPU bus: word RAM, console FIFO, status word, host preload.
// Optional write protection of low RAM is compiled in with `define CPU_MEM_WRITE_PROTECT_EN.
module cpu_mem_responder #(
  parameter int          ADDR_WIDTH    = 8,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] CONSOLE_ADDR  = 16'hFF00,
  parameter logic [15:0] STATUS_ADDR   = 16'hFF02,
  parameter logic [15:0] PROTECT_LIMIT = 16'h0040
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           addr,
  input  logic [15:0]           out_val,
  input  logic                  write_enable,
  output logic [15:0]           inp_val,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [15:0]           load_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overflow,
  output logic                  prot_fault
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_WORDS = 32'(1) << ADDR_WIDTH;
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  logic [15:0] mem_q [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [14:0] w;
  logic        is_console, is_status, is_ram, cpu_prot;
  logic        full, empty, push_req, push_ok, pop;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [15:0]           ram_wdata;
  logic                  unused_addr_b0;

  assign unused_addr_b0 = addr[0];
  assign w          = addr[15:1];
  assign is_console = (w == CONSOLE_ADDR[15:1]);
  assign is_status  = (w == STATUS_ADDR[15:1]);
  assign is_ram     = !is_console && !is_status && ({17'b0, w} < RAM_WORDS);

`ifdef CPU_MEM_WRITE_PROTECT_EN
  assign cpu_prot = is_ram && (addr < PROTECT_LIMIT);
`else
  assign cpu_prot = 1'b0;
`endif

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign overflow = overflow_q;

  assign push_req = write_enable && is_console;
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    inp_val = 16'hFFFF;
    if (is_console)     inp_val = 16'h0000;
    else if (is_status) inp_val = {13'b0, overflow_q, full, empty};
    else if (is_ram)    inp_val = mem_q[w[ADDR_WIDTH-1:0]];
  end

  // Host preload takes priority over a colliding CPU store.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = w[ADDR_WIDTH-1:0];
    ram_wdata = out_val;
    if (load_en) begin
      ram_we    = 1'b1;
      ram_waddr = load_addr;
      ram_wdata = load_data;
    end else if (write_enable && is_ram && !cpu_prot) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req && full && !pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push_ok) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push_ok) fifo_q[wr_ptr_q] <= out_val[7:0];
  end

`ifdef CPU_MEM_WRITE_PROTECT_EN
  logic prot_fault_q, prot_fault_d;

  assign prot_fault_d = prot_fault_q | (write_enable && cpu_prot);
  assign prot_fault   = prot_fault_q;

  always_ff @(posedge clock) begin
    if (!reset) prot_fault_q <= 1'b0;
    else        prot_fault_q <= prot_fault_d;
  end
`else
  assign prot_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (default parameters).
module tb_cpu_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr, out_val, inp_val, load_data;
  logic        write_enable, load_en, tx_valid, tx_ready, overflow, prot_fault;
  logic [7:0]  load_addr, tx_data;

  int checks   = 0;
  int failures = 0;

  cpu_mem_responder dut (
    .clock(clock), .reset(reset), .addr(addr), .out_val(out_val),
    .write_enable(write_enable), .inp_val(inp_val), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .overflow(overflow),
    .prot_fault(prot_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, inp_val, exp);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; out_val = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    load_addr = a; load_data = d; load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic drain(input logic [7:0] exp, input string tag);
    chk({tag, "_valid"}, 16'(tx_valid), 16'h0001);
    chk({tag, "_data"}, 16'(tx_data), 16'(exp));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; addr = '0; out_val = '0; write_enable = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
    chk("rst_overflow", 16'(overflow), 16'h0000);
    chk("rst_prot_fault", 16'(prot_fault), 16'h0000);

    // preload while reset is held
    preload(8'd0, 16'h2148);
    preload(8'd1, 16'h000E);
    reset = 1'b1;
    tick();
    rd(16'h0000, 16'h2148, "preload_w0");
    rd(16'h0003, 16'h000E, "preload_w1_odd");

    cpu_wr(16'h0080, 16'hBEEF);
    rd(16'h0080, 16'hBEEF, "store_load");
    rd(16'h4000, 16'hFFFF, "unmapped_rd");
    cpu_wr(16'h4000, 16'h1234);
    rd(16'h4000, 16'hFFFF, "unmapped_after_wr");
    rd(16'h0000, 16'h2148, "no_alias_w0");
    rd(16'h0080, 16'hBEEF, "no_alias_w40");

    cpu_wr(16'h01FE, 16'h5A5A);
    rd(16'h01FE, 16'h5A5A, "ram_top_word");
    rd(16'h0200, 16'hFFFF, "ram_past_top");

    rd(16'hFF00, 16'h0000, "console_rd");
    rd(16'hFF01, 16'h0000, "console_rd_odd");
    rd(16'hFF02, 16'h0001, "status_empty");
    rd(16'hFF03, 16'h0001, "status_odd");

    // preload beats a same-cycle CPU store to the same word
    addr = 16'h0080; out_val = 16'h1111; write_enable = 1'b1;
    load_addr = 8'h40; load_data = 16'h7777; load_en = 1'b1;
    tick();
    write_enable = 1'b0; load_en = 1'b0;
    rd(16'h0080, 16'h7777, "preload_wins");

    // console drain
    addr = 16'hFF00; out_val = 16'h006F; write_enable = 1'b1;
    #1;
    chk("no_bypass", 16'(tx_valid), 16'h0000);
    tick();
    write_enable = 1'b0;
    cpu_wr(16'hFF00, 16'h0073);
    cpu_wr(16'hFF00, 16'hAB65);
    rd(16'hFF02, 16'h0000, "status_partial");
    drain(8'h6F, "drain0");
    drain(8'h73, "drain1");
    drain(8'h65, "drain2");
    chk("drained_valid", 16'(tx_valid), 16'h0000);
    rd(16'hFF02, 16'h0001, "status_after_drain");

    // overflow
    for (int i = 0; i < 4; i++) cpu_wr(16'hFF00, 16'h0041 + 16'(i));
    rd(16'hFF02, 16'h0002, "status_full");
    cpu_wr(16'hFF00, 16'h0045);
    chk("overflow_set", 16'(overflow), 16'h0001);
    rd(16'hFF02, 16'h0006, "status_overflow");
    drain(8'h41, "ovf_drain0");
    drain(8'h42, "ovf_drain1");
    drain(8'h43, "ovf_drain2");
    drain(8'h44, "ovf_drain3");
    chk("ovf_drained_valid", 16'(tx_valid), 16'h0000);
    cpu_wr(16'hFF02, 16'hFFFF);
    rd(16'hFF02, 16'h0005, "status_wr_ignored");

    // reset clears flags/FIFO but not RAM, and beats a same-cycle push
    reset = 1'b0;
    addr = 16'hFF00; out_val = 16'h0099; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    chk("rst2_overflow", 16'(overflow), 16'h0000);
    chk("rst2_tx_valid", 16'(tx_valid), 16'h0000);
    reset = 1'b1;
    tick();
    rd(16'h0000, 16'h2148, "ram_survives_reset");

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) cpu_wr(16'hFF00, 16'h0010 + 16'(i));
    rd(16'hFF02, 16'h0002, "full_before_pop_push");
    addr = 16'hFF00; out_val = 16'h0014; write_enable = 1'b1; tx_ready = 1'b1;
    tick();
    write_enable = 1'b0; tx_ready = 1'b0;
    chk("pop_push_no_ovf", 16'(overflow), 16'h0000);
    rd(16'hFF02, 16'h0002, "pop_push_still_full");
    drain(8'h11, "pp_drain0");
    drain(8'h12, "pp_drain1");
    drain(8'h13, "pp_drain2");
    drain(8'h14, "pp_drain3");
    chk("pp_drained_valid", 16'(tx_valid), 16'h0000);

    // write protection
    preload(8'd8, 16'hAAAA);
    cpu_wr(16'h0010, 16'h1234);
`ifdef CPU_MEM_WRITE_PROTECT_EN
    rd(16'h0010, 16'hAAAA, "prot_blocked");
    chk("prot_fault_set", 16'(prot_fault), 16'h0001);
    cpu_wr(16'h0040, 16'h4321);
    rd(16'h0040, 16'h4321, "prot_limit_ok");
    preload(8'd8, 16'h5555);
    rd(16'h0010, 16'h5555, "prot_preload_ok");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("prot_fault_reset", 16'(prot_fault), 16'h0000);
`else
    rd(16'h0010, 16'h1234, "noprot_write_lands");
    chk("noprot_fault_zero", 16'(prot_fault), 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
